count_fsm_gen: RTL and testbench

- Parametrised successor to the single-channel start/flag count FSM.
- Measures how many whole programmable wait periods elapse between a start pulse and the stop flag.
- Adds over the previous generation: configurable counter/timer widths, one-shot or periodic re-arm mode, abort, done pulse and sticky overflow.
- Sits between the ranging/calibration control logic and the status registers; drives busy/count_value to the same bench-facing signal set.

---
 rtl/count_fsm_gen.sv | 133 +++++++++++++
 tb/tb_count_fsm_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_fsm_gen.sv
// Counts whole programmable wait periods between a start request and a stop flag.
// One-shot or periodic re-arm, abort, one-cycle done pulse and sticky overflow; all outputs registered.
module count_fsm_gen #(
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned WAIT_W    = 16,
    parameter int unsigned MAX_COUNT = 2**CNT_W-1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flag,
    input  logic              abort,
    input  logic              mode,
    input  logic [WAIT_W-1:0] wait_timer,
    output logic              busy,
    output logic [CNT_W-1:0]  count_value,
    output logic              done,
    output logic              overflow,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  MAX_C = CNT_W'(MAX_COUNT);
    localparam logic [WAIT_W-1:0] ONE_T = WAIT_W'(1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] timer_q, timer_d;
    logic [WAIT_W-1:0] period_q, period_d;
    logic              mode_q, mode_d;
    logic [CNT_W-1:0]  count_d;
    logic              overflow_d;
    logic              busy_d;
    logic              done_d;
    logic [WAIT_W-1:0] start_len;

    // A zero period would never expire, so it is treated as one cycle.
    assign start_len = (wait_timer == '0) ? ONE_T : wait_timer;
    assign state_dbg = state_q;

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            period_q    <= '0;
            mode_q      <= 1'b0;
            count_value <= '0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            period_q    <= period_d;
            mode_q      <= mode_d;
            count_value <= count_d;
            overflow    <= overflow_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // Next-state logic; abort outranks everything, then flag, then period expiry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (abort)                                         state_d = S_IDLE;
                else if (flag)                                     state_d = S_DONE;
                else if (timer_q == ONE_T && count_value == MAX_C) state_d = S_DONE;
            end
            S_DONE: begin
                if (abort)       state_d = S_IDLE;
                else if (mode_q) state_d = S_WAIT;
                else             state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath logic: next values for every registered output.
    always_comb begin
        timer_d    = timer_q;
        period_d   = period_q;
        mode_d     = mode_q;
        count_d    = count_value;
        overflow_d = overflow;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    period_d   = start_len;
                    mode_d     = mode;
                    timer_d    = start_len;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (!abort && !flag) begin
                    if (timer_q == ONE_T) begin
                        if (count_value == MAX_C) begin
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_value + 1'b1;
                            timer_d = period_q;
                        end
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!abort && mode_q) begin
                    count_d    = '0;
                    timer_d    = period_q;
                    overflow_d = 1'b0;
                end
            end
            default: ;
        endcase
        busy_d = (state_d == S_WAIT);
        done_d = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_count_fsm_gen.sv
// Directed bench for count_fsm_gen: per-cycle checks plus a done-pulse scoreboard
// whose monitor pops the expected {overflow, count} on every done pulse.
module tb_count_fsm_gen;

    localparam int CNT_W  = 5;
    localparam int WAIT_W = 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic              flag;
    logic              abort;
    logic              mode;
    logic [WAIT_W-1:0] wait_timer;
    logic              busy;
    logic [CNT_W-1:0]  count_value;
    logic              done;
    logic              overflow;
    logic [1:0]        state_dbg;

    logic [CNT_W:0] exp_q[$];
    int n_checks;
    int n_fail;

    count_fsm_gen #(.CNT_W(CNT_W), .WAIT_W(WAIT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .flag       (flag),
        .abort      (abort),
        .mode       (mode),
        .wait_timer (wait_timer),
        .busy       (busy),
        .count_value(count_value),
        .done       (done),
        .overflow   (overflow),
        .state_dbg  (state_dbg)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [CNT_W:0] exp_word(input logic ovf, input int cnt);
        return {ovf, CNT_W'(cnt)};
    endfunction

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int len, input logic m);
        wait_timer = WAIT_W'(len);
        mode       = m;
        start      = 1'b1;
        cyc();
        start      = 1'b0;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                logic [CNT_W:0] e;
                e = exp_q.pop_front();
                chk("done_count", 32'(count_value), 32'(e[CNT_W-1:0]));
                chk("done_overflow", 32'(overflow), 32'(e[CNT_W]));
                chk("done_busy_low", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        flag       = 1'b0;
        abort      = 1'b0;
        mode       = 1'b0;
        wait_timer = '0;

        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count_value), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // Basic one-shot: L=4, flag in cycle 11
        start_run(4, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            chk("t1_busy", 32'(busy), 32'd1);
            chk("t1_count", 32'(count_value), 32'((c - 1) / 4));
            if (c == 11) begin
                flag = 1'b1;
                exp_q.push_back(exp_word(1'b0, 2));
            end
            cyc();
        end
        flag = 1'b0;
        chk("t1_done_cycle", 32'(done), 32'd1);
        chk("t1_done_busy", 32'(busy), 32'd0);
        cyc();
        chk("t1_idle_done", 32'(done), 32'd0);
        repeat (3) cyc();
        chk("t1_idle_count", 32'(count_value), 32'd2);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Flag in the same cycle as the third expiry: no increment
        start_run(3, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            chk("t2_count", 32'(count_value), 32'((c - 1) / 3));
            if (c == 9) begin
                flag = 1'b1;
                exp_q.push_back(exp_word(1'b0, 2));
            end
            cyc();
        end
        flag = 1'b0;
        cyc();
        chk("t2_hold_count", 32'(count_value), 32'd2);

        // Saturation with L=1
        exp_q.push_back(exp_word(1'b1, 31));
        start_run(1, 1'b0);
        for (int c = 1; c <= 32; c++) begin
            chk("t3_count", 32'(count_value), 32'(c - 1));
            chk("t3_overflow", 32'(overflow), 32'd0);
            cyc();
        end
        chk("t3_sat_done", 32'(done), 32'd1);
        chk("t3_sat_overflow", 32'(overflow), 32'd1);
        cyc();
        chk("t3_sticky_overflow", 32'(overflow), 32'd1);
        chk("t3_sticky_count", 32'(count_value), 32'd31);
        chk("t3_idle_busy", 32'(busy), 32'd0);

        // Zero period behaves as L=1; flag after 5 WAIT cycles
        start_run(0, 1'b0);
        chk("t4_overflow_cleared", 32'(overflow), 32'd0);
        for (int c = 1; c <= 6; c++) begin
            chk("t4_count", 32'(count_value), 32'(c - 1));
            if (c == 6) begin
                flag = 1'b1;
                exp_q.push_back(exp_word(1'b0, 5));
            end
            cyc();
        end
        flag = 1'b0;
        cyc();
        chk("t4_hold_count", 32'(count_value), 32'd5);

        // Periodic mode, L=2; inputs changed mid-run must be ignored
        start_run(2, 1'b1);
        mode       = 1'b0;
        wait_timer = WAIT_W'(7);
        for (int c = 1; c <= 5; c++) begin
            chk("t5_busy", 32'(busy), 32'd1);
            chk("t5_count", 32'(count_value), 32'((c - 1) / 2));
            if (c == 5) begin
                flag = 1'b1;
                exp_q.push_back(exp_word(1'b0, 2));
            end
            cyc();
        end
        flag = 1'b0;
        chk("t5_done1", 32'(done), 32'd1);
        cyc();
        for (int j = 0; j <= 3; j++) begin
            chk("t5_rearm_busy", 32'(busy), 32'd1);
            chk("t5_rearm_count", 32'(count_value), 32'(j / 2));
            if (j == 3) begin
                flag = 1'b1;
                exp_q.push_back(exp_word(1'b0, 1));
            end
            cyc();
        end
        flag = 1'b0;
        chk("t5_done2", 32'(done), 32'd1);
        cyc();
        chk("t5_rearm2_busy", 32'(busy), 32'd1);
        chk("t5_rearm2_count", 32'(count_value), 32'd0);
        repeat (2) cyc();
        chk("t5_pre_abort_count", 32'(count_value), 32'd1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("t5_abort_busy", 32'(busy), 32'd0);
        repeat (4) cyc();
        chk("t5_abort_count", 32'(count_value), 32'd1);
        chk("t5_abort_state", 32'(state_dbg), 32'd0);

        // Abort at count 3; a start pulse during WAIT is ignored
        start_run(2, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            chk("t6_count", 32'(count_value), 32'((c - 1) / 2));
            start = (c == 3);
            abort = (c == 7);
            cyc();
        end
        start = 1'b0;
        abort = 1'b0;
        chk("t6_abort_busy", 32'(busy), 32'd0);
        repeat (3) cyc();
        chk("t6_abort_count", 32'(count_value), 32'd3);

        // start with abort in IDLE: stay idle
        start = 1'b1;
        abort = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        chk("t7_start_abort_busy", 32'(busy), 32'd0);
        chk("t7_start_abort_count", 32'(count_value), 32'd3);

        // Abort in DONE of a periodic run: done still pulses, no re-arm
        start_run(1, 1'b1);
        cyc();
        chk("t8_count", 32'(count_value), 32'd1);
        flag = 1'b1;
        exp_q.push_back(exp_word(1'b0, 1));
        cyc();
        flag  = 1'b0;
        abort = 1'b1;
        chk("t8_done", 32'(done), 32'd1);
        cyc();
        abort = 1'b0;
        chk("t8_no_rearm_busy", 32'(busy), 32'd0);
        chk("t8_no_rearm_count", 32'(count_value), 32'd1);
        cyc();
        chk("t8_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-WAIT, then a normal run
        start_run(3, 1'b0);
        repeat (4) cyc();
        chk("t9_pre_rst_count", 32'(count_value), 32'd1);
        chk("t9_pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t9_async_busy", 32'(busy), 32'd0);
        chk("t9_async_count", 32'(count_value), 32'd0);
        chk("t9_async_done", 32'(done), 32'd0);
        chk("t9_async_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("t9_post_rst_busy", 32'(busy), 32'd0);
        start_run(2, 1'b0);
        chk("t9_run_busy", 32'(busy), 32'd1);
        repeat (2) cyc();
        chk("t9_run_count", 32'(count_value), 32'd1);
        flag = 1'b1;
        exp_q.push_back(exp_word(1'b0, 1));
        cyc();
        flag = 1'b0;
        chk("t9_done", 32'(done), 32'd1);
        cyc();
        chk("t9_idle_count", 32'(count_value), 32'd1);

        repeat (3) cyc();
        chk("missing_done", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
